note_playback_engine: RTL and testbench

- Datapath partner of the recording/playback controller in the music device.
- Captures a note code into a 16-entry note memory on each `ld_note` pulse.
- During playback, reads the entry addressed by the controller's `note_counter` and drives a square-wave tone on `audio_out`.
- Inserts a short silent gap between successive notes so repeated notes are audible as separate notes.

---
 rtl/music_pkg.sv | 51 +++++
 rtl/tone_gen.sv | 37 +++
 rtl/note_playback_engine.sv | 161 ++++++++++++++++
 tb/tb_note_playback_engine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the note playback datapath: note codes, the
// half-period lookup for a 50 MHz clock, and the playback state encoding.
package music_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_CS4  = 4'd2;
  localparam logic [3:0] NOTE_D4   = 4'd3;
  localparam logic [3:0] NOTE_DS4  = 4'd4;
  localparam logic [3:0] NOTE_E4   = 4'd5;
  localparam logic [3:0] NOTE_F4   = 4'd6;
  localparam logic [3:0] NOTE_FS4  = 4'd7;
  localparam logic [3:0] NOTE_G4   = 4'd8;
  localparam logic [3:0] NOTE_GS4  = 4'd9;
  localparam logic [3:0] NOTE_A4   = 4'd10;
  localparam logic [3:0] NOTE_AS4  = 4'd11;
  localparam logic [3:0] NOTE_B4   = 4'd12;
  localparam logic [3:0] NOTE_C5   = 4'd13;
  localparam logic [3:0] NOTE_D5   = 4'd14;
  localparam logic [3:0] NOTE_E5   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_GAP
  } state_t;

  // Half period in clock cycles, CLK_HZ / (2 * f); a rest never enables the tone.
  function automatic logic [16:0] hp_of(input logic [3:0] code);
    case (code)
      NOTE_C4:  hp_of = 17'd95556;
      NOTE_CS4: hp_of = 17'd90193;
      NOTE_D4:  hp_of = 17'd85131;
      NOTE_DS4: hp_of = 17'd80353;
      NOTE_E4:  hp_of = 17'd75843;
      NOTE_F4:  hp_of = 17'd71586;
      NOTE_FS4: hp_of = 17'd67568;
      NOTE_G4:  hp_of = 17'd63776;
      NOTE_GS4: hp_of = 17'd60197;
      NOTE_A4:  hp_of = 17'd56818;
      NOTE_AS4: hp_of = 17'd53629;
      NOTE_B4:  hp_of = 17'd50619;
      NOTE_C5:  hp_of = 17'd47778;
      NOTE_D5:  hp_of = 17'd42566;
      NOTE_E5:  hp_of = 17'd37921;
      default:  hp_of = 17'd1;
    endcase
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: a load sets the half period and forces the output
// low; while enabled the output toggles every half_period cycles.
module tone_gen #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] half_period,
  output logic         tone
);

  logic [W-1:0] cnt;
  logic [W-1:0] reload;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      reload <= '0;
      tone   <= 1'b0;
    end else if (load) begin
      reload <= half_period - W'(1);
      cnt    <= half_period - W'(1);
      tone   <= 1'b0;
    end else if (enable) begin
      if (cnt == '0) begin
        cnt  <= reload;
        tone <= ~tone;
      end else begin
        cnt <= cnt - W'(1);
      end
    end
  end

endmodule

// File: rtl/note_playback_engine.sv
// Records note codes into a small memory and plays them back as square-wave
// tones, with a silent gap after each note-advance strobe.
module note_playback_engine
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned GAP_CYCLES = 2_500_000,
  parameter int unsigned HP_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_note,
  input  logic [3:0] note_in,
  input  logic       clear,
  input  logic       ld_play,
  input  logic [3:0] note_counter,
  input  logic       next_note_en,
  output logic       audio_out,
  output logic [3:0] cur_note,
  output logic       note_valid,
  output logic [4:0] rec_count,
  output logic       overflow
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [4:0]  FULL  = 5'(DEPTH);

  // The half-period table is only meaningful for a 50 MHz clock.
  if (CLK_HZ != 50_000_000) begin : g_hp_table_assumes_50mhz
  end

  state_t           state;
  state_t           state_next;
  logic             ld_note_q;
  logic [3:0]       mem [DEPTH];
  logic [3:0]       rd_data;
  logic             rd_in_range;
  logic             entry_q;
  logic [3:0]       cur_note_q;
  logic             note_valid_q;
  logic [GAP_W-1:0] gap_cnt;
  logic             tone;

  logic       ld_rise;
  logic       full;
  logic       wr_en;
  logic       entry;
  logic       gap_done;
  logic [3:0] entry_note;
  logic       tone_load;
  logic       tone_en;

  assign ld_rise    = ld_note & ~ld_note_q;
  assign full       = (rec_count == FULL);
  assign wr_en      = ld_rise & ~full & ~clear;
  assign entry      = (state == ST_PLAY) && entry_q;
  assign gap_done   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign entry_note = rd_in_range ? rd_data : NOTE_REST;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_note_q <= 1'b0;
      rec_count <= '0;
      overflow  <= 1'b0;
    end else begin
      ld_note_q <= ld_note;
      if (clear) begin
        rec_count <= '0;
        overflow  <= 1'b0;
      end else if (ld_rise) begin
        if (full) overflow  <= 1'b1;
        else      rec_count <= rec_count + 5'd1;
      end
    end
  end

  // NOTE: the note memory is deliberately not reset; rec_count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[rec_count[3:0]] <= note_in;
    if (state == ST_FETCH) rd_data <= mem[note_counter];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (ld_play) state_next = ST_FETCH;
      ST_FETCH: state_next = ST_PLAY;
      ST_PLAY:  if (next_note_en) state_next = ST_GAP;
      ST_GAP: begin
        if (next_note_en)  state_next = ST_GAP;
        else if (gap_done) state_next = ST_FETCH;
      end
    endcase
    if (!ld_play) state_next = ST_IDLE;
  end

  // Range check is frozen with the read so a moving note_counter cannot disturb PLAY entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q      <= 1'b0;
      rd_in_range  <= 1'b0;
      gap_cnt      <= '0;
      cur_note_q   <= NOTE_REST;
      note_valid_q <= 1'b0;
    end else begin
      entry_q <= (state == ST_FETCH);
      if (state == ST_FETCH) rd_in_range <= ({1'b0, note_counter} < rec_count);
      if (state != ST_GAP || next_note_en) gap_cnt <= '0;
      else                                 gap_cnt <= gap_cnt + GAP_W'(1);
      if (state == ST_IDLE) begin
        cur_note_q   <= NOTE_REST;
        note_valid_q <= 1'b0;
      end else if (entry) begin
        cur_note_q   <= entry_note;
        note_valid_q <= rd_in_range;
      end
    end
  end

  always_comb begin
    audio_out  = 1'b0;
    cur_note   = cur_note_q;
    note_valid = note_valid_q;
    tone_load  = 1'b0;
    tone_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        cur_note   = NOTE_REST;
        note_valid = 1'b0;
      end
      ST_PLAY: begin
        if (entry) begin
          cur_note   = entry_note;
          note_valid = rd_in_range;
          tone_load  = 1'b1;
        end else begin
          tone_en   = (cur_note_q != NOTE_REST);
          audio_out = tone & tone_en;
        end
      end
      default: ;
    endcase
  end

  tone_gen #(.W(HP_W)) u_tone (
    .clk         (clk),
    .reset       (reset),
    .load        (tone_load),
    .enable      (tone_en),
    .half_period (HP_W'(hp_of(entry_note))),
    .tone        (tone)
  );

endmodule

// File: tb/tb_note_playback_engine.sv
// Directed bench for note_playback_engine: a table of write-path vectors plus
// hand-written playback, gap, overflow and reset sequences.
module tb_note_playback_engine;

  localparam int unsigned GAP   = 4;
  localparam int unsigned HP_A4 = 56818;
  localparam int unsigned HP_B4 = 50619;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_note;
  logic [3:0] note_in;
  logic       clear;
  logic       ld_play;
  logic [3:0] note_counter;
  logic       next_note_en;
  logic       audio_out;
  logic [3:0] cur_note;
  logic       note_valid;
  logic [4:0] rec_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       ld;
    logic [3:0] note;
    logic       clr;
    logic [4:0] exp_rc;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[11];

  note_playback_engine #(.GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .ld_note      (ld_note),
    .note_in      (note_in),
    .clear        (clear),
    .ld_play      (ld_play),
    .note_counter (note_counter),
    .next_note_en (next_note_en),
    .audio_out    (audio_out),
    .cur_note     (cur_note),
    .note_valid   (note_valid),
    .rec_count    (rec_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_note(input logic [3:0] code);
    ld_note = 1'b1;
    note_in = code;
    step();
    ld_note = 1'b0;
    step();
  endtask

  task automatic check_silent(input string name, input int cycles);
    int highs;
    highs = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (audio_out) highs++;
    end
    check(name, highs, 0);
  endtask

  initial begin
    int lows;
    int steps;

    // Inputs applied on one negedge, results checked on the next.
    vecs[0]  = '{1'b1, 4'd3, 1'b0, 5'd1, 1'b0};
    vecs[1]  = '{1'b1, 4'd4, 1'b0, 5'd1, 1'b0};
    vecs[2]  = '{1'b0, 4'd0, 1'b0, 5'd1, 1'b0};
    vecs[3]  = '{1'b1, 4'd7, 1'b1, 5'd0, 1'b0};
    vecs[4]  = '{1'b0, 4'd0, 1'b0, 5'd0, 1'b0};
    vecs[5]  = '{1'b1, 4'd2, 1'b0, 5'd1, 1'b0};
    vecs[6]  = '{1'b0, 4'd0, 1'b0, 5'd1, 1'b0};
    vecs[7]  = '{1'b1, 4'd6, 1'b0, 5'd2, 1'b0};
    vecs[8]  = '{1'b0, 4'd0, 1'b0, 5'd2, 1'b0};
    vecs[9]  = '{1'b1, 4'd8, 1'b0, 5'd3, 1'b0};
    vecs[10] = '{1'b0, 4'd0, 1'b0, 5'd3, 1'b0};

    reset        = 1'b1;
    ld_note      = 1'b0;
    note_in      = 4'd0;
    clear        = 1'b0;
    ld_play      = 1'b0;
    note_counter = 4'd0;
    next_note_en = 1'b0;
    step(2);
    check("rst_audio", audio_out, 0);
    check("rst_cur_note", cur_note, 0);
    check("rst_note_valid", note_valid, 0);
    check("rst_rec_count", rec_count, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 11; i++) begin
      ld_note = vecs[i].ld;
      note_in = vecs[i].note;
      clear   = vecs[i].clr;
      step();
      check($sformatf("vec%0d_rec_count", i), rec_count, vecs[i].exp_rc);
      check($sformatf("vec%0d_overflow", i), overflow, vecs[i].exp_ovf);
    end
    clear = 1'b0;

    // Memory now holds 2, 6, 8; address 5 is beyond rec_count.
    note_counter = 4'd5;
    ld_play      = 1'b1;
    step(2);
    check("oor_note_valid", note_valid, 0);
    check("oor_cur_note", cur_note, 0);
    check_silent("oor_audio", 20);
    ld_play = 1'b0;
    step();
    check("idle_cur_note", cur_note, 0);

    note_counter = 4'd2;
    ld_play      = 1'b1;
    step(2);
    check("play2_cur_note", cur_note, 8);
    check("play2_note_valid", note_valid, 1);
    step(3);
    next_note_en = 1'b1;
    ld_play      = 1'b0;
    step();
    next_note_en = 1'b0;
    check("idle_wins_cur_note", cur_note, 0);
    check("idle_wins_note_valid", note_valid, 0);
    check("idle_wins_audio", audio_out, 0);

    ld_note = 1'b1;
    note_in = 4'd11;
    step(100);
    ld_note = 1'b0;
    step();
    check("held_load_rec_count", rec_count, 4);

    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_rec_count", rec_count, 0);
    for (int i = 0; i < 17; i++) pulse_note((i == 0) ? 4'd5 : 4'd9);
    check("full_rec_count", rec_count, 16);
    check("full_overflow", overflow, 1);
    note_counter = 4'd0;
    ld_play      = 1'b1;
    step(2);
    check("mem0_kept_cur_note", cur_note, 5);
    check("mem0_kept_note_valid", note_valid, 1);
    step(10);
    ld_play = 1'b0;
    step();
    check("drop_play_cur_note", cur_note, 0);
    check("drop_play_note_valid", note_valid, 0);
    check("drop_play_audio", audio_out, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear2_rec_count", rec_count, 0);
    check("clear2_overflow", overflow, 0);

    // Gap, advance and re-fetch.
    pulse_note(4'd1);
    pulse_note(4'd12);
    note_counter = 4'd0;
    ld_play      = 1'b1;
    step(2);
    check("gap_first_cur_note", cur_note, 1);
    step(3);
    next_note_en = 1'b1;
    note_counter = 4'd1;
    step();
    next_note_en = 1'b0;
    for (int i = 0; i < GAP; i++) begin
      check($sformatf("gap%0d_audio", i), audio_out, 0);
      check($sformatf("gap%0d_cur_note", i), cur_note, 1);
      step();
    end
    check("fetch_cur_note_held", cur_note, 1);
    step();
    check("adv_cur_note", cur_note, 12);
    check("adv_note_valid", note_valid, 1);
    step();
    check("adv_hp_loaded", dut.u_tone.cnt, HP_B4 - 1);
    step();
    check("adv_hp_decrement", dut.u_tone.cnt, HP_B4 - 2);

    // A second strobe mid-gap restarts the gap count.
    note_counter = 4'd0;
    next_note_en = 1'b1;
    step();
    next_note_en = 1'b0;
    step();
    next_note_en = 1'b1;
    steps = 0;
    while (cur_note != 4'd1 && steps < 50) begin
      step();
      steps++;
      next_note_en = 1'b0;
    end
    check("gap_restart_cycles", steps, 6);

    // A4 playback, then asynchronous reset while the tone is high.
    ld_play = 1'b0;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    pulse_note(4'd10);
    check("a4_rec_count", rec_count, 1);
    note_counter = 4'd0;
    ld_play      = 1'b1;
    step(2);
    check("a4_cur_note", cur_note, 10);
    check("a4_note_valid", note_valid, 1);
    lows = 0;
    for (int c = 0; c < 60000; c++) begin
      step();
      if (audio_out) break;
      lows++;
    end
    check("a4_half_period", lows, HP_A4);
    check("a4_audio_high", audio_out, 1);

    #2 reset = 1'b1;
    #1;
    check("async_rst_audio", audio_out, 0);
    check("async_rst_cur_note", cur_note, 0);
    check("async_rst_note_valid", note_valid, 0);
    check("async_rst_rec_count", rec_count, 0);
    check("async_rst_overflow", overflow, 0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_fetch_cur_note", cur_note, 0);
    step();
    check("post_rst_rest_cur_note", cur_note, 0);
    check("post_rst_rest_note_valid", note_valid, 0);
    check_silent("post_rst_rest_audio", 20);
    ld_play = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
